// File: rtl/i2s_pkg.sv
// i2s_pkg: shared definitions for the I2S/TDM transmitter.
//   fmt_e       - serial data alignment (I2S one-BCK delay or left-justified)
//   frame_bits  - BCK periods per frame (channels * slot width)
//   cnt_w       - counter width able to hold 0..n-1 (minimum 1 bit)
//   params_ok   - legal parameter combination check for integration flows
package i2s_pkg;

    typedef enum logic {
        FMT_I2S = 1'b0,
        FMT_LJ  = 1'b1
    } fmt_e;

    localparam int unsigned SAMPLE_W_MIN = 8;
    localparam int unsigned SAMPLE_W_MAX = 24;
    localparam int unsigned BCK_DIV_MIN  = 2;

    function automatic int unsigned frame_bits(input int unsigned channels,
                                               input int unsigned slot_w);
        return channels * slot_w;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic bit params_ok(input int unsigned sample_w,
                                     input int unsigned slot_w,
                                     input int unsigned channels,
                                     input int unsigned bck_div);
        return (sample_w >= SAMPLE_W_MIN) && (sample_w <= SAMPLE_W_MAX) &&
               (slot_w >= sample_w) &&
               ((channels == 2) || (channels == 4) || (channels == 8)) &&
               (bck_div >= BCK_DIV_MIN) && ((bck_div % 2) == 0);
    endfunction

endpackage

// File: rtl/i2s_bck_gen.sv
// i2s_bck_gen: divides the core clock down to the I2S bit clock.
//   clk, reset - core clock, synchronous active-high reset
//   bck        - bit clock: low for the first half of each BCK_DIV period
//   fe         - strobe on the last clk of a BCK period; registers updated
//                on this strobe change together with the BCK falling edge
module i2s_bck_gen
    import i2s_pkg::*;
#(
    parameter int unsigned BCK_DIV = 8
) (
    input  logic clk,
    input  logic reset,
    output logic bck,
    output logic fe
);

    localparam int unsigned DW = cnt_w(BCK_DIV);
    localparam logic [DW-1:0] LAST = DW'(BCK_DIV - 1);
    localparam logic [DW-1:0] HALF = DW'(BCK_DIV / 2);

    logic [DW-1:0] div_cnt;

    assign fe  = (div_cnt == LAST);
    assign bck = (div_cnt >= HALF);

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (fe) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

endmodule

// File: rtl/i2s_tdm_tx.sv
// i2s_tdm_tx: serialises CHANNELS samples of SAMPLE_W bits into I2S (2 ch)
// or TDM (>2 ch) frames of SLOT_W-bit slots.
//   clk, reset    - core clock, synchronous active-high reset
//   sample_in     - one frame of samples, channel 0 in the LSBs
//   sample_valid  - sample_in valid; sample_ready - holding register empty
//   mute          - frame loaded while high is all zeros
//   i2s_bck       - bit clock; i2s_lrck - word select / frame sync
//   i2s_data      - serial data, MSB first
//   frame_start   - one-clk pulse as each new frame appears on the pins
//   underrun      - sticky: a frame was loaded with the holding register empty
module i2s_tdm_tx
    import i2s_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned SLOT_W   = 32,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned BCK_DIV  = 8,
    parameter int unsigned LJ_MODE  = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CHANNELS*SAMPLE_W-1:0] sample_in,
    input  logic                         sample_valid,
    output logic                         sample_ready,
    input  logic                         mute,
    output logic                         i2s_bck,
    output logic                         i2s_lrck,
    output logic                         i2s_data,
    output logic                         frame_start,
    output logic                         underrun
);

    localparam int unsigned FB = frame_bits(CHANNELS, SLOT_W);
    localparam int unsigned BW = cnt_w(FB);
    localparam int unsigned DW = CHANNELS * SAMPLE_W;
    localparam logic [BW-1:0] LAST_BIT = BW'(FB - 1);
    localparam fmt_e FMT = (LJ_MODE != 0) ? FMT_LJ : FMT_I2S;

    logic          fe;
    logic          started;
    logic [BW-1:0] bit_cnt;
    logic [BW-1:0] next_bit;
    logic          holding_full;
    logic [DW-1:0] holding;
    logic [FB-1:0] shift_reg;
    logic [FB-1:0] frame_vec;
    logic          lag;
    logic          load;
    logic          xfer;
    logic          serial_bit;
    logic          lrck_next;

    i2s_bck_gen #(
        .BCK_DIV(BCK_DIV)
    ) u_bck_gen (
        .clk  (clk),
        .reset(reset),
        .bck  (i2s_bck),
        .fe   (fe)
    );

    // The first fe after reset always loads, so frame 0 begins right away.
    assign load         = fe & (~started | (bit_cnt == LAST_BIT));
    assign sample_ready = ~holding_full;
    assign xfer         = sample_valid & ~holding_full;

    // Frame image in serial order: bit FB-1 is the first bit on the wire.
    always_comb begin
        frame_vec = '0;
        if (holding_full && !mute) begin
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                frame_vec[FB-1-k*SLOT_W -: SAMPLE_W] = holding[k*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    always_comb begin
        serial_bit = load ? frame_vec[FB-1] : shift_reg[FB-1];
        next_bit   = load ? '0 : bit_cnt + BW'(1);
        if (CHANNELS == 2) begin
            lrck_next = (next_bit >= BW'(SLOT_W));
        end else begin
            lrck_next = (next_bit == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            started      <= 1'b0;
            bit_cnt      <= '0;
            holding_full <= 1'b0;
            holding      <= '0;
            shift_reg    <= '0;
            lag          <= 1'b0;
            i2s_lrck     <= 1'b0;
            i2s_data     <= 1'b0;
            frame_start  <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            frame_start <= load;
            if (fe) begin
                started   <= 1'b1;
                bit_cnt   <= next_bit;
                shift_reg <= load ? (frame_vec << 1) : (shift_reg << 1);
                // In I2S alignment every bit goes out one BCK late; lag carries
                // the last bit of the previous frame into bit 0 of the next.
                lag       <= serial_bit;
                i2s_data  <= (FMT == FMT_LJ) ? serial_bit : lag;
                i2s_lrck  <= lrck_next;
            end
            if (load && !holding_full) begin
                underrun <= 1'b1;
            end
            // Accepting only when empty means a same-clk load sees the old
            // (empty) contents while the new sample stays held.
            if (xfer) begin
                holding      <= sample_in;
                holding_full <= 1'b1;
            end else if (load) begin
                holding_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// tb_i2s_tdm_tx: three DUT configurations (I2S stereo, LJ stereo, 4-ch TDM
// with 24-bit samples), each checked every clk against a frame-level model,
// plus literal expectations for the first frame and the underrun flag.
module tb_i2s_tdm_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;

    task automatic chk(input int cfg, input string nm,
                       input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL cfg%0d %s @%0t: got %0h expected %0h", cfg, nm, $time, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
        localparam int unsigned CH  = (gi == 2) ? 4 : 2;
        localparam int unsigned SW  = (gi == 2) ? 24 : 16;
        localparam int unsigned SL  = 32;
        localparam int unsigned DIV = 8;
        localparam int unsigned LJ  = (gi == 1) ? 1 : 0;
        localparam int unsigned FB  = CH * SL;
        localparam int unsigned FC  = FB * DIV;
        localparam int unsigned NW  = CH * SW;
        localparam logic [95:0] DIR_ALL = (gi == 2) ? 96'h123456_000000_7FFFFF_800000
                                                    : 96'h8001A55A;
        localparam logic [127:0] EXP_DATA =
            (gi == 0) ? {64'b0, 1'b0, 16'hA55A, 15'b0, 1'b0, 16'h8001, 15'b0} :
            (gi == 1) ? {64'b0, 16'hA55A, 16'b0, 16'h8001, 16'b0} :
                        {1'b0, 24'h800000, 8'b0, 24'h7FFFFF, 8'b0, 24'h0, 8'b0, 24'h123456, 7'b0};
        localparam logic [127:0] EXP_LRCK = (gi == 2) ? {1'b1, 127'b0} : {96'b0, 32'hFFFFFFFF};

        logic          rst, sv, mt;
        logic [NW-1:0] sin;
        logic          bck, lrck, dat, ready, fs, und;

        i2s_tdm_tx #(
            .SAMPLE_W(SW),
            .SLOT_W  (SL),
            .CHANNELS(CH),
            .BCK_DIV (DIV),
            .LJ_MODE (LJ)
        ) u_dut (
            .clk         (clk),
            .reset       (rst),
            .sample_in   (sin),
            .sample_valid(sv),
            .sample_ready(ready),
            .mute        (mt),
            .i2s_bck     (bck),
            .i2s_lrck    (lrck),
            .i2s_data    (dat),
            .frame_start (fs),
            .underrun    (und)
        );

        // Model: u = clk edges since reset; cur/prev = frames on the wire.
        int unsigned   u, nfr;
        bit            full, und_m, cap_en;
        logic [NW-1:0] hold, cur, prev;
        logic [127:0]  cap_d, cap_l;
        logic          m_r;

        // Bit s of a frame in wire order: slot s/SL, sample MSB first, then pad.
        function automatic logic fbit(input logic [NW-1:0] f, input int unsigned s);
            int unsigned slot = s / SL;
            int unsigned pos  = s % SL;
            if (pos >= SW) return 1'b0;
            return f[slot*SW + (SW-1-pos)];
        endfunction

        function automatic logic [NW-1:0] rnd();
            logic [95:0] r = {$urandom(), $urandom(), $urandom()};
            return r[NW-1:0];
        endfunction

        task automatic model_step(input logic r, input logic v,
                                  input logic [NW-1:0] d, input logic m);
            int unsigned e;
            bit ld, xf;
            if (r) begin
                u = 0; nfr = 0; full = 0; und_m = 0;
                hold = '0; cur = '0; prev = '0;
            end else begin
                e  = u + 1;
                ld = (e >= DIV) && (((e - DIV) % FC) == 0);
                xf = v && !full;
                if (ld) begin
                    prev = cur;
                    cur  = (full && !m) ? hold : '0;
                    if (!full) und_m = 1;
                    full = 0;
                    nfr++;
                end
                if (xf) begin
                    hold = d;
                    full = 1;
                end
                u = e;
            end
        endtask

        task automatic check_cycle();
            int unsigned p, b;
            logic e_l, e_d, e_f;
            e_l = 1'b0; e_d = 1'b0; e_f = 1'b0;
            if (u >= DIV) begin
                p   = u / DIV - 1;
                b   = p % FB;
                e_f = ((u % DIV) == 0) && (b == 0);
                e_l = (CH == 2) ? (b >= SL) : (b == 0);
                if (LJ != 0)       e_d = fbit(cur, b);
                else if (b > 0)    e_d = fbit(cur, b - 1);
                else if (nfr >= 2) e_d = fbit(prev, FB - 1);
                if (cap_en && nfr == 1 && (u % DIV) == DIV / 2) begin
                    cap_d[FB-1-b] = dat;
                    cap_l[FB-1-b] = lrck;
                end
            end
            chk(gi, "bck",         128'(bck),   128'((u % DIV) >= DIV / 2));
            chk(gi, "lrck",        128'(lrck),  128'(e_l));
            chk(gi, "data",        128'(dat),   128'(e_d));
            chk(gi, "frame_start", 128'(fs),    128'(e_f));
            chk(gi, "ready",       128'(ready), 128'(!full));
            chk(gi, "underrun",    128'(und),   128'(und_m));
        endtask

        task automatic tick(input logic r, input logic v,
                            input logic [NW-1:0] d, input logic m);
            rst = r; sv = v; sin = d; mt = m;
            model_step(r, v, d, m);
            @(negedge clk);
            check_cycle();
        endtask

        initial begin
            cap_d = '0; cap_l = '0; cap_en = 0; m_r = 1'b0;
            repeat (3) tick(1'b1, 1'b0, '0, 1'b0);

            // One sample before the first frame, then nothing: frame 1 underruns.
            cap_en = 1;
            tick(1'b0, 1'b1, DIR_ALL[NW-1:0], 1'b0);
            repeat (DIV + 2*FC) tick(1'b0, 1'b0, rnd(), 1'b0);
            cap_en = 0;
            chk(gi, "frame0_data_literal", cap_d, EXP_DATA);
            chk(gi, "frame0_lrck_literal", cap_l, EXP_LRCK);
            chk(gi, "underrun_set_literal", 128'(und), 128'(1'b1));

            // Continuous valid with changing data.
            repeat (3*FC) tick(1'b0, 1'b1, rnd(), 1'b0);

            // Random valid, occasional mute toggles.
            repeat (3*FC) begin
                if ($urandom_range(0, 299) == 0) m_r = ~m_r;
                tick(1'b0, $urandom_range(0, 3) != 0, rnd(), m_r);
            end

            // Full-scale data, then mute raised part way through a frame.
            repeat (FC + FC/3) tick(1'b0, 1'b1, '1, 1'b0);
            repeat (2*FC) tick(1'b0, 1'b1, '1, 1'b1);

            // Reset somewhere inside a frame.
            repeat (FC/2 + $urandom_range(0, FC/4)) tick(1'b0, $urandom_range(0, 1) != 0, rnd(), 1'b0);
            repeat (2) tick(1'b1, 1'b1, rnd(), 1'b0);
            chk(gi, "underrun_cleared_literal", 128'(und), 128'(1'b0));
            chk(gi, "lrck_reset_literal", 128'(lrck), 128'(1'b0));

            // No sample_valid at all after reset.
            repeat (DIV + 2*FC) tick(1'b0, 1'b0, rnd(), 1'b0);
            chk(gi, "underrun_idle_literal", 128'(und), 128'(1'b1));
            chk(gi, "ready_idle_literal", 128'(ready), 128'(1'b1));

            n_done++;
        end
    end

    initial begin
        for (int i = 0; i < 60000 && n_done < 3; i++) @(posedge clk);
        if (n_done < 3) begin
            n_fail++;
            $display("FAIL timeout: got %0d configs done expected 3", n_done);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
